uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8-bit UART transmitter with optional parity, started by a trigger rising edge
//   clk_i       - single clock, rising edge
//   rstn_i      - synchronous active-low reset
//   tr_signal_i - transmit trigger (clk_i-synchronous); a rising edge in IDLE starts a frame
//   data_i      - byte to send, latched when the trigger is accepted
//   tx_o        - registered serial line, idle high
//   busy_o      - high while a frame is on the line
//   done_o      - one-cycle pulse in the first idle cycle after a frame
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 10416,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       tr_signal_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] sh_q, sh_d;
    logic par_q, par_d, trig_q, tx_q, tx_d, busy_q, done_q, done_d, start, last;
    assign start = tr_signal_i & ~trig_q;
    assign last = cnt_q == CW'(CLKS_PER_BIT - 1);
    assign tx_o = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    always_comb begin
        state_d = state_q;
        cnt_d = last ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        sh_d = sh_q;
        par_d = par_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = START;
                    sh_d = data_i;
                    par_d = PARITY_ODD ? ~^data_i : ^data_i;
                    idx_d = 3'd0;
                end
            end
            START: if (last) state_d = DATA;
            DATA: if (last) begin
                if (idx_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
                else begin
                    idx_d = idx_q + 3'd1;
                    sh_d = sh_q >> 1;
                end
            end
            PARITY: if (last) state_d = STOP;
            STOP: if (last) begin
                state_d = IDLE;
                done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered from the next state so they line up with it
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= 3'd0;
            sh_q <= 8'd0;
            par_q <= 1'b0;
            trig_q <= 1'b1;
            tx_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            sh_q <= sh_d;
            par_q <= par_d;
            trig_q <= tr_signal_i;
            tx_q <= tx_d;
            busy_q <= state_d != IDLE;
            done_q <= done_d;
        end
    end
endmodule
